wisc_regfile_bypass: RTL and testbench



---
 rtl/wisc_regfile_bypass.sv | 96 +++++++++
 tb/tb_wisc_regfile_bypass.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wisc_regfile_bypass.sv
// wisc_regfile_bypass
//   8 x 16-bit architectural register file fed by the write-back stage and
//   read by the two decode-stage ports. R0 is an ordinary register.
//   Holds a sticky halt latch that freezes architectural state, a saturating
//   committed-write counter and a one-cycle error pulse on writes after halt.
//
// Optional feature (macro WISC_RF_BYPASS_EN):
//   defined     -> a committing write is forwarded to a matching read port
//                  in the same cycle
//   not defined -> reads always return stored contents
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/addr/data     write-back write port
//   halt_in             halt indication from write-back
//   rd_addr1/2          read addresses
//   rd_data1/2          read data, combinational
//   halted              sticky halt status, registered
//   wr_count            committed writes since reset, saturating, registered
//   err                 write-attempt-after-halt pulse, registered
module wisc_regfile_bypass #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              halt_in,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              halted,
  output logic [CNT_W-1:0]  wr_count,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              commit_c;

  // Writes are only architecturally visible before the halt latch sets.
  assign commit_c = wr_en & ~halted_q;

  // Next-state logic.
  always_comb begin
    regs_d   = regs_q;
    halted_d = halted_q | halt_in;
    err_d    = wr_en & halted_q;
    cnt_d    = cnt_q;
    if (commit_c) begin
      regs_d[wr_addr] = wr_data;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Read ports; the forward path is gated by rst_n so reset reads stay zero.
`ifdef WISC_RF_BYPASS_EN
  logic fwd_ok_c;
  assign fwd_ok_c = commit_c & rst_n;
  assign rd_data1 = (fwd_ok_c && (wr_addr == rd_addr1)) ? wr_data : regs_q[rd_addr1];
  assign rd_data2 = (fwd_ok_c && (wr_addr == rd_addr2)) ? wr_data : regs_q[rd_addr2];
`else
  assign rd_data1 = regs_q[rd_addr1];
  assign rd_data2 = regs_q[rd_addr2];
`endif

  assign halted   = halted_q;
  assign wr_count = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wisc_regfile_bypass.sv
// Self-checking bench for wisc_regfile_bypass: directed scenarios plus random
// traffic compared against a behavioural model of the register file.
module tb_wisc_regfile_bypass;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned CNT_W  = 4;   // small counter so saturation is reachable
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              halt_in;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              halted;
  logic [CNT_W-1:0]  wr_count;
  logic              err;

  wisc_regfile_bypass #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .halt_in(halt_in),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .halted(halted), .wr_count(wr_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  int  m_regs [NREGS];
  bit  m_halted;
  int  m_cnt;
  bit  m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = 0;
    m_halted = 0;
    m_cnt    = 0;
    m_err    = 0;
  endtask

  // Value a read port should present in the current cycle.
  function automatic int exp_read(input int addr);
`ifdef WISC_RF_BYPASS_EN
    if (wr_en && !m_halted && int'(wr_addr) == addr) return int'(wr_data);
`endif
    return m_regs[addr];
  endfunction

  // One clock cycle: drive at negedge, check reads, then model the edge.
  task automatic cycle(input bit we, input int wa, input int wd, input bit h,
                       input int ra1, input int ra2);
    @(negedge clk);
    wr_en    = we;
    wr_addr  = ADDR_W'(wa);
    wr_data  = DATA_W'(wd);
    halt_in  = h;
    rd_addr1 = ADDR_W'(ra1);
    rd_addr2 = ADDR_W'(ra2);
    #1;
    check_eq("rd_data1", 32'(rd_data1), 32'(exp_read(ra1)));
    check_eq("rd_data2", 32'(rd_data2), 32'(exp_read(ra2)));
    @(posedge clk);
    m_err = we && m_halted;
    if (we && !m_halted) begin
      m_regs[wa] = wd & 16'hFFFF;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if (h) m_halted = 1;
    #1;
    check_eq("halted",   32'(halted),   32'(m_halted));
    check_eq("wr_count", 32'(wr_count), 32'(m_cnt));
    check_eq("err",      32'(err),      32'(m_err));
  endtask

  task automatic rand_cycle(input bit allow_halt);
    bit h;
    h = allow_halt && ($urandom_range(0, 19) == 0);
    cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)),
          int'($urandom_range(0, 16'hFFFF)), h,
          int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)));
  endtask

  // Drop reset between edges and check outputs clear without a clock edge.
  task automatic async_reset(input int addr);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = 16'h5A5A;
    rd_addr1 = ADDR_W'(addr); rd_addr2 = ADDR_W'((addr + 1) % NREGS);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_rd1",      32'(rd_data1), 32'h0);
    check_eq("rst_rd2",      32'(rd_data2), 32'h0);
    check_eq("rst_halted",   32'(halted),   32'h0);
    check_eq("rst_wr_count", 32'(wr_count), 32'h0);
    check_eq("rst_err",      32'(err),      32'h0);
    @(posedge clk); #1;
    check_eq("rst_hold_rd1", 32'(rd_data1), 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; halt_in = 1'b0;
    rd_addr1 = 3'd3; rd_addr2 = 3'd7;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("init_rd1",    32'(rd_data1), 32'h0);
    check_eq("init_rd2",    32'(rd_data2), 32'h0);
    check_eq("init_halted", 32'(halted),   32'h0);
    check_eq("init_cnt",    32'(wr_count), 32'h0);
    check_eq("init_err",    32'(err),      32'h0);

    // Write/read-back on consecutive edges
    cycle(1, 2, 16'hA5A5, 0, 3, 7);
    cycle(1, 5, 16'h1234, 0, 2, 5);
    cycle(0, 0, 0, 0, 2, 5);
    check_eq("wb_rd1", 32'(rd_data1), 32'hA5A5);
    check_eq("wb_rd2", 32'(rd_data2), 32'h1234);
    check_eq("wb_cnt", 32'(wr_count), 32'd2);

    // Same-cycle write/read of R4
    cycle(1, 4, 16'h0001, 0, 0, 1);
    cycle(1, 4, 16'hBEEF, 0, 4, 4);
    cycle(0, 0, 0, 0, 4, 0);

    // Random traffic without halt; drives the counter into saturation
    for (int i = 0; i < 200; i++) rand_cycle(0);
    check_eq("sat_cnt", 32'(wr_count), 32'(CNT_MAX));

    // Reset with register contents and saturated counter
    async_reset(2);
    cycle(0, 0, 0, 0, 2, 5);

    // Halt in the same cycle as a write: the write commits
    cycle(1, 1, 16'h00FF, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    check_eq("halt_r1", 32'(rd_data1), 32'h00FF);
    cycle(1, 1, 16'hFFFF, 0, 1, 2);
    check_eq("halt_err_pulse", 32'(err), 32'h1);
    cycle(0, 1, 0, 0, 1, 2);
    check_eq("halt_err_clear", 32'(err), 32'h0);
    check_eq("halt_r1_frozen", 32'(rd_data1), 32'h00FF);
    for (int i = 0; i < 40; i++) rand_cycle(0);

    // Reset clears the halt latch; random traffic with occasional halts
    async_reset(1);
    for (int i = 0; i < 150; i++) rand_cycle(1);
    async_reset(int'($urandom_range(0, NREGS - 1)));
    for (int i = 0; i < 100; i++) rand_cycle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
